// File: rtl/inst_seq.sv
// inst_seq: multi-cycle fetch/execute/memory/writeback sequencer for the hxd32 core.
// Define INST_SEQ_CNT_EN to build the retired-instruction counter; otherwise inst_cnt_o reads 0.
module inst_seq #(
    parameter int XLEN        = 32,
    parameter int BUS_TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            run_i,
    output logic            iram_rd_req_o,
    input  logic            iram_rd_ack_i,
    input  logic [XLEN-1:0] inst_data_i,
    output logic [XLEN-1:0] inst_data_o,
    input  logic            dec_rd_wr_en_i,
    input  logic [1:0]      dec_rd_wr_sel_i,
    input  logic            dec_dram_wr_en_i,
    output logic            dram_req_o,
    input  logic            dram_ack_i,
    output logic            pc_wr_en_o,
    output logic            rd_wr_en_o,
    output logic            dram_wr_en_o,
    output logic            busy_o,
    output logic            err_o,
    output logic [31:0]     inst_cnt_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        WB    = 3'd4,
        ERR   = 3'd5
    } state_t;

    // Last wait count at which an ack is still accepted; one more miss traps.
    localparam logic [15:0] WAIT_LAST = 16'(BUS_TIMEOUT - 1);

    state_t            state_r;
    state_t            state_s;
    logic [15:0]       wait_cnt_r;
    logic              wait_inc_s;
    logic [XLEN-1:0]   inst_r;
    logic              mem_op_s;

    assign mem_op_s    = dec_dram_wr_en_i | (dec_rd_wr_sel_i == 2'b01);
    assign inst_data_o = inst_r;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and bus wait bookkeeping.
    always_comb begin
        state_s    = state_r;
        wait_inc_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (run_i) begin
                    state_s = FETCH;
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                if (iram_rd_ack_i) begin
                    state_s = EXEC;
                end else if (wait_cnt_r >= WAIT_LAST) begin
                    state_s = ERR;
                end else begin
                    wait_inc_s = 1'b1;
                end
            end
            EXEC: begin
                if (mem_op_s) begin
                    state_s = MEM;
                end else begin
                    state_s = WB;
                end
            end
            MEM: begin
                if (dram_ack_i) begin
                    state_s = WB;
                end else if (wait_cnt_r >= WAIT_LAST) begin
                    state_s = ERR;
                end else begin
                    wait_inc_s = 1'b1;
                end
            end
            WB: begin
                if (run_i) begin
                    state_s = FETCH;
                end else begin
                    state_s = IDLE;
                end
            end
            ERR:     state_s = ERR;
            default: state_s = ERR;
        endcase
    end

    // Strobes are pure decodes of the registered state.
    always_comb begin
        iram_rd_req_o = 1'b0;
        dram_req_o    = 1'b0;
        dram_wr_en_o  = 1'b0;
        pc_wr_en_o    = 1'b0;
        rd_wr_en_o    = 1'b0;
        busy_o        = 1'b0;
        err_o         = 1'b0;
        case (state_r)
            IDLE: busy_o = 1'b0;
            FETCH: begin
                busy_o        = 1'b1;
                iram_rd_req_o = 1'b1;
            end
            EXEC: busy_o = 1'b1;
            MEM: begin
                busy_o       = 1'b1;
                dram_req_o   = 1'b1;
                dram_wr_en_o = dec_dram_wr_en_i;
            end
            WB: begin
                busy_o     = 1'b1;
                pc_wr_en_o = 1'b1;
                rd_wr_en_o = dec_rd_wr_en_i;
            end
            ERR:     err_o = 1'b1;
            default: err_o = 1'b1;
        endcase
    end

    // Wait counter: runs only while a request is outstanding, zero otherwise.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt_r <= 16'd0;
        end else if (wait_inc_s) begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
        end else begin
            wait_cnt_r <= 16'd0;
        end
    end

    // Instruction register, loaded only by an acknowledged fetch.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inst_r <= {XLEN{1'b0}};
        end else if ((state_r == FETCH) && iram_rd_ack_i) begin
            inst_r <= inst_data_i;
        end else begin
            inst_r <= inst_r;
        end
    end

`ifdef INST_SEQ_CNT_EN
    logic [31:0] inst_cnt_r;

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inst_cnt_r <= 32'd0;
        end else if (state_r == WB) begin
            inst_cnt_r <= inst_cnt_r + 32'd1;
        end else begin
            inst_cnt_r <= inst_cnt_r;
        end
    end

    assign inst_cnt_o = inst_cnt_r;
`else
    assign inst_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_inst_seq.sv
// Self-checking bench for inst_seq: random instruction mixes with random memory latencies,
// checked against per-instruction cycle/strobe budgets derived from the sequencing rules.
module tb_inst_seq;

    localparam int XLEN = 32;
    localparam int TMO  = 4;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            run_i = 1'b0;
    logic            iram_rd_req_o;
    logic            iram_rd_ack_i = 1'b0;
    logic [XLEN-1:0] inst_data_i = 32'd0;
    logic [XLEN-1:0] inst_data_o;
    logic            dec_rd_wr_en_i = 1'b0;
    logic [1:0]      dec_rd_wr_sel_i = 2'b00;
    logic            dec_dram_wr_en_i = 1'b0;
    logic            dram_req_o;
    logic            dram_ack_i = 1'b0;
    logic            pc_wr_en_o;
    logic            rd_wr_en_o;
    logic            dram_wr_en_o;
    logic            busy_o;
    logic            err_o;
    logic [31:0]     inst_cnt_o;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] exp_cnt = 32'd0;

    inst_seq #(.XLEN(XLEN), .BUS_TIMEOUT(TMO)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .run_i            (run_i),
        .iram_rd_req_o    (iram_rd_req_o),
        .iram_rd_ack_i    (iram_rd_ack_i),
        .inst_data_i      (inst_data_i),
        .inst_data_o      (inst_data_o),
        .dec_rd_wr_en_i   (dec_rd_wr_en_i),
        .dec_rd_wr_sel_i  (dec_rd_wr_sel_i),
        .dec_dram_wr_en_i (dec_dram_wr_en_i),
        .dram_req_o       (dram_req_o),
        .dram_ack_i       (dram_ack_i),
        .pc_wr_en_o       (pc_wr_en_o),
        .rd_wr_en_o       (rd_wr_en_o),
        .dram_wr_en_o     (dram_wr_en_o),
        .busy_o           (busy_o),
        .err_o            (err_o),
        .inst_cnt_o       (inst_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_model();
`ifdef INST_SEQ_CNT_EN
        return exp_cnt;
`else
        return 32'd0;
`endif
    endfunction

    task automatic do_reset();
        rst_i = 1'b1;
        run_i = 1'b0;
        iram_rd_ack_i = 1'b0;
        dram_ack_i = 1'b0;
        exp_cnt = 32'd0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // kind: 0 = ALU, 1 = load, 2 = store. fw/mw = wait cycles before the ack.
    task automatic run_inst(input logic [31:0] word, input int fw, input int mw, input int kind,
                            input logic rd_en, input logic run_after, input logic drop_in_mem);
        int   f = 0, m = 0, busy_cyc = 0, rd_cnt = 0, pc_cnt = 0, dwr = 0, stray = 0;
        logic done = 1'b0;
        logic mem = (kind != 0);
        int   sel;
        dec_rd_wr_en_i   = rd_en;
        dec_dram_wr_en_i = (kind == 2);
        sel = $urandom_range(0, 2);
        dec_rd_wr_sel_i  = (kind == 1) ? 2'b01 : (sel == 0) ? 2'b00 : (sel == 1) ? 2'b10 : 2'b11;
        run_i = 1'b1;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk_i);
            if (busy_o) busy_cyc++;
            if (iram_rd_req_o) f++;
            if (dram_req_o) m++;
            if (dram_wr_en_o) dwr++;
            if (rd_wr_en_o && !pc_wr_en_o) stray++;
            if (dram_wr_en_o && !dram_req_o) stray++;
            if (pc_wr_en_o) begin
                pc_cnt++;
                if (rd_wr_en_o) rd_cnt++;
                done = 1'b1;
                chk("inst_cnt_wb", inst_cnt_o, cnt_model());
                exp_cnt = exp_cnt + 32'd1;
                run_i = run_after;
            end
            iram_rd_ack_i = iram_rd_req_o ? (f == fw + 1) : ($urandom_range(0, 3) == 0);
            inst_data_i   = (iram_rd_req_o && f == fw + 1) ? word : $urandom();
            dram_ack_i    = dram_req_o ? (m == mw + 1) : ($urandom_range(0, 3) == 0);
            if (drop_in_mem && dram_req_o) run_i = 1'b0;
        end
        chk("inst_done", {31'd0, done}, 32'd1);
        chk("busy_cycles", busy_cyc, 3 + fw + (mem ? mw + 1 : 0));
        chk("pc_pulses", pc_cnt, 1);
        chk("rd_pulses", rd_cnt, {31'd0, rd_en});
        chk("dram_req_cycles", m, mem ? mw + 1 : 0);
        chk("dram_wr_cycles", dwr, (kind == 2) ? mw + 1 : 0);
        chk("stray_strobes", stray, 0);
        chk("inst_data", inst_data_o, word);
    endtask

    task automatic idle_check(input string tag);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
            chk({tag, "_req"}, {31'd0, iram_rd_req_o}, 32'd0);
        end
        chk({tag, "_cnt"}, inst_cnt_o, cnt_model());
    endtask

    // Never acknowledge one of the two memories and check the error trap.
    task automatic hang(input logic in_mem);
        int   waits = 0;
        int   strobes = 0;
        logic trapped = 1'b0;
        do_reset();
        dec_dram_wr_en_i = 1'b1;
        dec_rd_wr_en_i   = 1'b1;
        dec_rd_wr_sel_i  = 2'b00;
        run_i = 1'b1;
        for (int c = 0; c < 40 && !trapped; c++) begin
            @(negedge clk_i);
            if (in_mem ? dram_req_o : iram_rd_req_o) waits++;
            if (pc_wr_en_o || rd_wr_en_o) strobes++;
            trapped = err_o;
            iram_rd_ack_i = in_mem ? iram_rd_req_o : 1'b0;
            dram_ack_i = 1'b0;
        end
        chk("tmo_trapped", {31'd0, trapped}, 32'd1);
        chk("tmo_wait_cycles", waits, TMO);
        chk("tmo_strobes", strobes, 0);
        for (int i = 0; i < 6; i++) begin
            run_i = $urandom_range(0, 1);
            iram_rd_ack_i = $urandom_range(0, 1);
            dram_ack_i = $urandom_range(0, 1);
            @(negedge clk_i);
            chk("err_sticky", {26'd0, err_o, busy_o, iram_rd_req_o, dram_req_o, pc_wr_en_o, dram_wr_en_o},
                32'h20);
        end
    endtask

    initial begin
        // Reset state with run already requested.
        run_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_outs", {25'd0, iram_rd_req_o, dram_req_o, pc_wr_en_o, rd_wr_en_o, dram_wr_en_o, busy_o, err_o},
            32'd0);
        chk("rst_inst", inst_data_o, 32'd0);
        chk("rst_cnt", inst_cnt_o, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("first_fetch", {31'd0, iram_rd_req_o}, 32'd1);

        do_reset();
        run_inst(32'h0050_0093, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        idle_check("alu");
        run_inst(32'h00A1_2023, 0, 2, 2, 1'b0, 1'b0, 1'b0);
        idle_check("store");
        run_inst(32'h0001_2083, TMO - 1, TMO - 1, 1, 1'b1, 1'b0, 1'b0);
        idle_check("edge_wait");
        run_inst(32'h0041_2103, 1, 2, 1, 1'b1, 1'b0, 1'b1);
        idle_check("stop");

        for (int i = 0; i < 40; i++) begin
            run_inst($urandom(), $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1),
                     $urandom_range(0, 2), 1'($urandom_range(0, 1)), (i != 39), 1'b0);
        end
        idle_check("random");

        // Reset mid-store must abort without strobes.
        dec_dram_wr_en_i = 1'b1;
        dec_rd_wr_sel_i  = 2'b00;
        run_i = 1'b1;
        iram_rd_ack_i = 1'b1;
        inst_data_i = 32'hDEAD_BEEF;
        dram_ack_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("pre_abort_mem", {31'd0, dram_req_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        chk("abort_outs", {27'd0, dram_req_o, dram_wr_en_o, pc_wr_en_o, busy_o, err_o}, 32'd0);
        chk("abort_inst", inst_data_o, 32'd0);
        chk("abort_cnt", inst_cnt_o, 32'd0);
        do_reset();

`ifdef INST_SEQ_CNT_EN
        dut.inst_cnt_r = 32'hFFFF_FFFF;
        exp_cnt = 32'hFFFF_FFFF;
        run_inst(32'h0000_0013, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("cnt_wrap", inst_cnt_o, 32'd0);
`endif

        hang(1'b0);
        hang(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_seq.md
Name: inst_seq

Overview:
- Multi-cycle control sequencer for the hxd32 core.
- Fetches an instruction word over a request/acknowledge handshake and holds it in an instruction register that feeds the decoder.
- Gates the decoder's register-file and data-RAM write enables so that each fires once per instruction, in the correct phase.
- Handles variable-latency instruction and data memories, with a bus-timeout error trap and an optional retired-instruction counter.

Parameters:
XLEN, 32, instruction/data word width
BUS_TIMEOUT, 255, max wait cycles in FETCH or MEM before error; legal range 1..65535

Ports:
clk_i  in  1  core clock
rst_i  in  1  asynchronous reset, active-high
run_i  in  1  1 = execute instructions; 0 = stop at next instruction boundary
iram_rd_req_o  out  1  instruction fetch request
iram_rd_ack_i  in  1  fetch data valid on inst_data_i
inst_data_i  in  XLEN  fetched instruction word
inst_data_o  out  XLEN  latched instruction register, drives decoder
dec_rd_wr_en_i  in  1  decoder register-write enable (ungated)
dec_rd_wr_sel_i  in  2  decoder writeback source; 2'b01 = data RAM
dec_dram_wr_en_i  in  1  decoder store enable (ungated)
dram_req_o  out  1  data RAM access request
dram_ack_i  in  1  data RAM access complete
pc_wr_en_o  out  1  PC update strobe
rd_wr_en_o  out  1  gated register-file write enable
dram_wr_en_o  out  1  gated store enable
busy_o  out  1  1 whenever state is not IDLE or ERR
err_o  out  1  sticky bus-timeout error
inst_cnt_o  out  32  retired-instruction count

Behaviour:
- Reset (asynchronous, rst_i=1):
  - state=IDLE; inst_data_o=0; wait counter=0.
  - All outputs 0, including err_o and inst_cnt_o.
  - Reset asserted mid-instruction aborts the instruction immediately; no write strobe is issued.
- States (3-bit encoding): IDLE=0, FETCH=1, EXEC=2, MEM=3, WB=4, ERR=5.
- IDLE:
  - All strobes 0.
  - run_i=1 -> FETCH.
- FETCH:
  - iram_rd_req_o=1.
  - On iram_rd_ack_i=1: latch inst_data_i into inst_data_o -> EXEC.
- EXEC:
  - One cycle; decoder and ALU settle on the latched word.
  - If dec_dram_wr_en_i=1 or dec_rd_wr_sel_i=2'b01 -> MEM; otherwise -> WB.
- MEM:
  - dram_req_o=1.
  - dram_wr_en_o=dec_dram_wr_en_i, held for the whole MEM stay.
  - On dram_ack_i=1 -> WB.
- WB:
  - One cycle; pc_wr_en_o=1 and rd_wr_en_o=dec_rd_wr_en_i.
  - inst_cnt_o increments, wrapping from 0xFFFFFFFF to 0.
  - Next state: FETCH if run_i=1, else IDLE.
- Strobe timing: all strobes are combinational decodes of the registered state; no strobe is asserted outside its state.
- Latency:
  - Non-memory instruction with zero-wait fetch: 3 cycles (FETCH, EXEC, WB).
  - Load or store adds 1 + memory wait cycles.
- Wait counter:
  - Clears on every entry to FETCH or MEM; increments each cycle spent waiting for ack.
  - When the counter reaches BUS_TIMEOUT with no ack -> ERR.
  - An ack in the same cycle as the limit wins: normal transition.
- ERR:
  - err_o=1; all strobes and requests 0.
  - Held until reset; run_i is ignored.
- run_i deasserted mid-instruction: the current instruction completes through WB, then the block goes to IDLE.
- Acks received outside their request state are ignored.
- inst_data_o holds its value until the next successful fetch.

Optional Feature:
INST_SEQ_CNT_EN
- Defined: inst_cnt_o is a 32-bit register counting WB cycles.
- Undefined: no counter register; inst_cnt_o is tied to 0.

Test Plan:
- Reset: hold rst_i=1, run_i=1 -> all outputs 0; release reset -> iram_rd_req_o=1 on the first clock.
- ALU instruction, zero-wait fetch: run_i=1, ack on the first FETCH cycle, inst 0x00500093, dec_rd_wr_en_i=1 -> inst_data_o=0x00500093; rd_wr_en_o and pc_wr_en_o high exactly 1 cycle, 3 cycles after fetch start; inst_cnt_o=1.
- Store with 2-cycle dram wait: dec_dram_wr_en_i=1, dec_rd_wr_en_i=0 -> dram_req_o and dram_wr_en_o high 3 cycles; rd_wr_en_o never asserts; pc_wr_en_o pulses once.
- Timeout: BUS_TIMEOUT=4, never ack the fetch -> ERR after 4 wait cycles with err_o=1, iram_rd_req_o=0; run_i toggling has no effect until reset.
- Stop at boundary: drop run_i during MEM of a load -> WB still completes with rd_wr_en_o=1, then IDLE, busy_o=0, no further fetch.
- Counter wrap (INST_SEQ_CNT_EN defined): force count to 0xFFFFFFFF, retire one instruction -> inst_cnt_o=0; rebuild without the macro -> inst_cnt_o stays 0 throughout.
